// File: rtl/mem_responder.sv
// mem_responder: DEPTH x 32-bit word store with a registered instruction
// fetch port, a read/write data port and a full-array clear sweep.
module mem_responder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ReadPC,
    output logic [31:0] Instr,
    input  logic [31:0] RWAddr,
    input  logic [31:0] Value,
    input  logic        OP2En,
    input  logic        OP2RW,
    output logic [31:0] Data,
    output logic        DataValid,
    input  logic        Clear,
    output logic        Busy,
    output logic        AddrErr
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } stateT;

    stateT             state, nextState;
    logic [AW-1:0]     sweepCnt;
    logic [31:0]       mem [DEPTH];

    logic              memWe;
    logic [AW-1:0]     memWAddr;
    logic [31:0]       memWData;
    logic              rdAccept;
    logic              accessAccept;
    logic              loadCnt;
    logic              incCnt;

    logic [AW-1:0]     fetchIdx;
    logic [AW-1:0]     dataIdx;
    logic              upperBitsSet;

    assign fetchIdx     = ReadPC[AW-1:0];
    assign dataIdx      = RWAddr[AW-1:0];
    assign upperBitsSet = |RWAddr[31:AW];
    assign Busy         = (state == SWEEP);

    // Next-state and datapath control; Clear beats a data access in IDLE,
    // and every data access is dropped while sweeping.
    always_comb begin
        nextState    = state;
        memWe        = 1'b0;
        memWAddr     = dataIdx;
        memWData     = Value;
        rdAccept     = 1'b0;
        accessAccept = 1'b0;
        loadCnt      = 1'b0;
        incCnt       = 1'b0;
        unique case (state)
            IDLE: begin
                if (Clear) begin
                    nextState = SWEEP;
                    loadCnt   = 1'b1;
                end else if (OP2En) begin
                    accessAccept = 1'b1;
                    if (OP2RW) begin
                        memWe = 1'b1;
                    end else begin
                        rdAccept = 1'b1;
                    end
                end
            end
            SWEEP: begin
                memWe    = 1'b1;
                memWAddr = sweepCnt;
                memWData = 32'd0;
                incCnt   = 1'b1;
                if (sweepCnt == AW'(DEPTH - 1)) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State register and sweep counter; reset aborts any sweep in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            sweepCnt <= '0;
        end else begin
            state <= nextState;
            if (loadCnt) begin
                sweepCnt <= '0;
            end else if (incCnt) begin
                sweepCnt <= sweepCnt + AW'(1);
            end
        end
    end

    // Array write port; contents are never reset, reset only suppresses writes.
    always_ff @(posedge Clk) begin
        if (!Reset && memWe) begin
            mem[memWAddr] <= memWData;
        end
    end

    // Registered fetch: reads pre-write content, forced to zero while sweeping.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Instr <= 32'd0;
        end else if (state == SWEEP) begin
            Instr <= 32'd0;
        end else begin
            Instr <= mem[fetchIdx];
        end
    end

    // Data-port read result, valid strobe and out-of-range address flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Data      <= 32'd0;
            DataValid <= 1'b0;
            AddrErr   <= 1'b0;
        end else begin
            DataValid <= rdAccept;
            AddrErr   <= accessAccept && upperBitsSet;
            if (rdAccept) begin
                Data <= mem[dataIdx];
            end
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, words of storage (power of two, 2..1024).
REQ-002 Parameter AW, default 6, word-index width, log2(DEPTH).
REQ-003 Clk  input  1  single clock, all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 ReadPC  input  32  instruction fetch word address.
REQ-006 Instr  output  32  fetched instruction word.
REQ-007 RWAddr  input  32  data-port word address.
REQ-008 Value  input  32  data-port write value.
REQ-009 OP2En  input  1  data-port operation request, sampled per cycle.
REQ-010 OP2RW  input  1  data-port direction: 1 write, 0 read.
REQ-011 Data  output  32  data-port read result.
REQ-012 DataValid  output  1  one-cycle pulse, Data holds a new read result.
REQ-013 Clear  input  1  request to zero the whole array.
REQ-014 Busy  output  1  high while a clear sweep is in progress.
REQ-015 AddrErr  output  1  one-cycle pulse, accepted access had nonzero bits above AW.

Function
REQ-016 Storage SHALL be DEPTH x 32-bit words, indexed by address bits [AW-1:0]; upper bits SHALL be ignored for indexing (wrap-around).
REQ-017 FSM states SHALL be IDLE and SWEEP only.
REQ-018 IDLE: Clear high at an edge -> SWEEP with sweep counter loaded to 0, Busy high from the next cycle.
REQ-019 SWEEP: each cycle SHALL write 0 to word[counter] and increment counter; after writing word DEPTH-1 -> IDLE, Busy low the following cycle (sweep = DEPTH cycles).
REQ-020 Clear asserted during SWEEP SHALL be ignored; the sweep SHALL NOT restart.
REQ-021 Instr SHALL be registered: Instr at edge N+1 = word[ReadPC[AW-1:0]] as held before edge N (1-cycle latency, read-before-write).
REQ-022 In SWEEP, Instr SHALL be registered as 0.
REQ-023 In IDLE with OP2En=1, OP2RW=1 and Clear=0, word[RWAddr[AW-1:0]] SHALL be written with Value at the edge.
REQ-024 In IDLE with OP2En=1, OP2RW=0 and Clear=0, Data SHALL load old word[RWAddr[AW-1:0]] and DataValid SHALL pulse high for exactly the next cycle.
REQ-025 Data SHALL hold its last value when no read is accepted; DataValid SHALL be 0.
REQ-026 Clear and OP2En in the same IDLE cycle: Clear wins; data access dropped, no DataValid, no write.
REQ-027 Any OP2En during SWEEP SHALL be dropped (no write, no DataValid, no AddrErr).
REQ-028 Fetch and write to the same word in one cycle: Instr SHALL return pre-write content; the following fetch returns the new value.
REQ-029 AddrErr SHALL pulse for one cycle after an accepted data access with RWAddr[31:AW] != 0; the access SHALL still complete on the wrapped index.
REQ-030 Back-to-back reads SHALL be accepted every cycle, one DataValid per read.

Reset
REQ-031 Reset high at an edge SHALL force IDLE, counter 0, Instr=0, Data=0, DataValid=0, Busy=0, AddrErr=0.
REQ-032 Reset SHALL take priority over Clear, OP2En and an in-progress sweep (sweep aborts; already-zeroed words stay zero).
REQ-033 Reset SHALL NOT alter array contents other than via an aborted sweep.

Verification
REQ-034 Write Value=32'hDEADBEEF at RWAddr=5, then read RWAddr=5 -> Data=32'hDEADBEEF with one DataValid pulse, one cycle after the read request.
REQ-035 Preload words 0..63, pulse Clear -> Busy high exactly 64 cycles; subsequent fetches of every ReadPC 0..63 return 0; Clear pulsed mid-sweep does not extend Busy.
REQ-036 ReadPC=3 and write Value=7 to RWAddr=3 in the same cycle (old content 1) -> Instr=1 next cycle, Instr=7 on the following fetch.
REQ-037 Write RWAddr=32'h00000041 with Value=9 (DEPTH=64) -> AddrErr pulses once; read RWAddr=1 returns 9.
REQ-038 Clear and read request in the same IDLE cycle -> no DataValid, sweep runs; OP2En write during sweep leaves target word 0.
REQ-039 Reset asserted at sweep cycle 10 -> Busy=0 and all outputs 0 next cycle; words 0..9 read 0, word 20 keeps its preloaded value.
